crypt_selftest_seq: RTL and testbench
=====================================

CRYPT_SELFTEST_SEQ -- requirements
Module: crypt_selftest_seq

Interface
REQ-001 SHALL have parameter pBYTECNT_SIZE, default 7: subbyte field width of the register address.
REQ-002 SHALL have parameter pTEXT_BYTES, default 16: number of text bytes written per run (1..2^pBYTECNT_SIZE).
REQ-003 SHALL have parameter pKEY_BYTES, default 16: number of key bytes written per run (1..2^pBYTECNT_SIZE).
REQ-004 SHALL have parameter pOUT_BYTES, default 16: number of result bytes read per run (1..2^pBYTECNT_SIZE).
REQ-005 SHALL have parameters pREG_TEXTIN, pREG_KEY, pREG_GO and pREG_CIPHEROUT, each 6 bits, defaults 4, 5, 6 and 7: register addresses.
REQ-006 SHALL have parameter pRD_LAT, default 2: cycles from the reg_read pulse to valid reg_rdata (≥1).
REQ-007 SHALL have parameter pPOLL_GAP, default 4: idle cycles between busy polls.
REQ-008 SHALL have parameter pTIMEOUT, default 30000: maximum cycles from the GO write to a poll returning not-busy.
REQ-009 usb_clk  in  1  single clock; all logic is on the rising edge.
REQ-010 resetn  in  1  synchronous, active-low reset.
REQ-011 start_i  in  1  run request, sampled high for one cycle.
REQ-012 mode_i  in  2  run mode: 0 = full run; 1 = skip key write; 2 = no compare; 3 = key write only.
REQ-013 clr_i  in  1  clears err_count_o.
REQ-014 text_i, key_i, expected_i  in  8*pTEXT_BYTES, 8*pKEY_BYTES, 8*pOUT_BYTES  run vectors; byte k = bits [8k+7:8k].
REQ-015 reg_addr_o  out  8+pBYTECNT_SIZE  {2'b00, reg[5:0], subbyte}.
REQ-016 reg_wdata_o  out  8  write data.
REQ-017 reg_write_o, reg_read_o  out  1 each  single-cycle access strobes.
REQ-018 reg_rdata_i  in  8  read data.
REQ-019 busy_o, done_o, pass_o, fail_o, timeout_o  out  1 each  status outputs.
REQ-020 result_o  out  8*pOUT_BYTES  captured result.
REQ-021 err_count_o  out  16  count of failed runs.
REQ-022 latency_o  out  16  cycle count from the GO write to the final poll.

Function
REQ-023 SHALL implement the states IDLE, WR_TEXT, WR_KEY, WR_GO, POLL_RD, POLL_GAP, RD_OUT, CMP and DONE.
REQ-024 start_i in IDLE SHALL be accepted and SHALL latch mode_i, text_i, key_i and expected_i; start_i outside IDLE SHALL be ignored.
REQ-025 Writes SHALL be issued as one reg_write_o pulse per cycle, with no gaps, beginning the cycle after start is accepted.
REQ-026 Write order SHALL be: text subbytes 0..pTEXT_BYTES-1, then key subbytes 0..pKEY_BYTES-1, then pREG_GO subbyte 0 with data 8'h01.
REQ-027 Mode 1 SHALL omit the key writes.
REQ-028 Mode 3 SHALL write the key only, then go directly to DONE with pass_o=1.
REQ-029 Each read SHALL consist of one reg_read_o pulse, after which reg_rdata_i is captured exactly pRD_LAT cycles later; reg_addr_o SHALL be held stable for the whole read.
REQ-030 POLL_RD SHALL read pREG_GO subbyte 0.
REQ-031 If the polled bit0 is 1, the block SHALL wait pPOLL_GAP cycles in POLL_GAP and then poll again.
REQ-032 If the polled bit0 is 0, the block SHALL go to RD_OUT.
REQ-033 The timeout counter SHALL start at the GO write; upon reaching pTIMEOUT it SHALL set timeout_o=1 and fail_o=1, skip RD_OUT and go to DONE; a poll already in flight SHALL be abandoned.
REQ-034 RD_OUT SHALL read pREG_CIPHEROUT subbytes 0..pOUT_BYTES-1 in ascending order, placing byte k in result_o[8k+7:8k].
REQ-035 CMP SHALL take one cycle: pass_o = (result_o == expected_i), else fail_o=1; mode 2 SHALL force pass_o=1.
REQ-036 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-037 busy_o SHALL be high in every state except IDLE.
REQ-038 pass_o, fail_o, timeout_o, result_o and latency_o SHALL hold their values until the next accepted start, at which point pass_o, fail_o and timeout_o clear.
REQ-039 err_count_o SHALL increment on each DONE with fail_o=1 and SHALL saturate at 16'hFFFF.
REQ-040 clr_i SHALL zero err_count_o; if clr_i coincides with an increment, clear SHALL win.
REQ-041 latency_o SHALL saturate at 16'hFFFF.
REQ-042 Outside active accesses, reg_write_o and reg_read_o SHALL be 0.
REQ-043 reg_wdata_o SHALL be 0 whenever reg_write_o is 0.

Reset
REQ-044 resetn=0 at a clock edge SHALL force IDLE and zero every output and counter at that edge, including mid-run.
REQ-045 A start_i coinciding with reset SHALL be dropped.

Verification
REQ-046 Full run, defaults; slave returns busy for 3 polls, then result 128'h8a278bf8fa2812bc39e52c76205af377 equal to expected -> exactly 33 consecutive writes, 4 polls, 16 reads, pass_o=1, done_o pulsed once, err_count_o=0.
REQ-047 Same run with expected_i differing in bit 0 -> fail_o=1, err_count_o=1; a second failing run gives 2; asserting clr_i together with a third failing DONE gives 0.
REQ-048 Mode 1 -> 17 writes with no pREG_KEY address seen; mode 3 -> 16 key writes, no GO write, pass_o=1.
REQ-049 Slave busy forever, pTIMEOUT=200 -> timeout_o=1, fail_o=1, zero pREG_CIPHEROUT reads, done_o within 200+pRD_LAT+1 cycles of the GO write.
REQ-050 start_i pulsed during RD_OUT -> ignored, with no extra accesses.
REQ-051 resetn low during POLL_GAP -> all outputs 0 the next cycle; a fresh start then completes normally.

Source files
------------

// File: rtl/crypt_selftest_seq.sv
// Crypto core self-test sequencer: writes text/key/GO over a register bus, polls busy,
// reads the result back and compares it against the expected vector.
module crypt_selftest_seq #(
  parameter int unsigned pBYTECNT_SIZE  = 7,
  parameter int unsigned pTEXT_BYTES    = 16,
  parameter int unsigned pKEY_BYTES     = 16,
  parameter int unsigned pOUT_BYTES     = 16,
  parameter logic [5:0]  pREG_TEXTIN    = 6'd4,
  parameter logic [5:0]  pREG_KEY       = 6'd5,
  parameter logic [5:0]  pREG_GO        = 6'd6,
  parameter logic [5:0]  pREG_CIPHEROUT = 6'd7,
  parameter int unsigned pRD_LAT        = 2,
  parameter int unsigned pPOLL_GAP      = 4,
  parameter int unsigned pTIMEOUT       = 30000
) (
  input  logic                        usb_clk,
  input  logic                        resetn,
  input  logic                        start_i,
  input  logic [1:0]                  mode_i,
  input  logic                        clr_i,
  input  logic [8*pTEXT_BYTES-1:0]    text_i,
  input  logic [8*pKEY_BYTES-1:0]     key_i,
  input  logic [8*pOUT_BYTES-1:0]     expected_i,
  output logic [8+pBYTECNT_SIZE-1:0]  reg_addr_o,
  output logic [7:0]                  reg_wdata_o,
  output logic                        reg_write_o,
  output logic                        reg_read_o,
  input  logic [7:0]                  reg_rdata_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        pass_o,
  output logic                        fail_o,
  output logic                        timeout_o,
  output logic [8*pOUT_BYTES-1:0]     result_o,
  output logic [15:0]                 err_count_o,
  output logic [15:0]                 latency_o
);

  localparam int unsigned CW = pBYTECNT_SIZE;
  localparam int unsigned AW = 8 + pBYTECNT_SIZE;
  localparam int unsigned SW = 16;
  localparam int unsigned TW = 32;

  typedef enum logic [3:0] {
    IDLE, WR_TEXT, WR_KEY, WR_GO, POLL_RD, POLL_GAP, RD_OUT, CMP, DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic [8*pTEXT_BYTES-1:0]  text_q, text_d;
  logic [8*pKEY_BYTES-1:0]   key_q, key_d;
  logic [8*pOUT_BYTES-1:0]   expct_q, expct_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [SW-1:0]             sub_q, sub_d;
  logic [TW-1:0]             tcnt_q, tcnt_d, tcnt_inc;
  logic [AW-1:0]             addr_q, addr_d;
  logic [7:0]                wdata_q, wdata_d;
  logic                      wr_q, wr_d, rd_q, rd_d;
  logic                      busy_q, busy_d, done_q, done_d;
  logic                      pass_q, pass_d, fail_q, fail_d, to_q, to_d;
  logic [8*pOUT_BYTES-1:0]   result_q, result_d;
  logic [15:0]               err_q, err_d, lat_q, lat_d;
  logic                      wait_st;

  always_ff @(posedge usb_clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      text_q   <= '0;
      key_q    <= '0;
      expct_q  <= '0;
      cnt_q    <= '0;
      sub_q    <= '0;
      tcnt_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      to_q     <= 1'b0;
      result_q <= '0;
      err_q    <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      text_q   <= text_d;
      key_q    <= key_d;
      expct_q  <= expct_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      tcnt_q   <= tcnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      to_q     <= to_d;
      result_q <= result_d;
      err_q    <= err_d;
      lat_q    <= lat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    text_d   = text_q;
    key_d    = key_q;
    expct_d  = expct_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    tcnt_d   = tcnt_q;
    tcnt_inc = tcnt_q + TW'(1);
    pass_d   = pass_q;
    fail_d   = fail_q;
    to_d     = to_q;
    result_d = result_q;
    err_d    = err_q;
    lat_d    = lat_q;
    wait_st  = (state_q == WR_GO) || (state_q == POLL_RD) || (state_q == POLL_GAP);

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          text_d  = text_i;
          key_d   = key_i;
          expct_d = expected_i;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          to_d    = 1'b0;
          cnt_d   = '0;
          sub_d   = '0;
          tcnt_d  = '0;
          state_d = (mode_i == 2'd3) ? WR_KEY : WR_TEXT;
        end
      end
      WR_TEXT: begin
        if (cnt_q == CW'(pTEXT_BYTES - 1)) begin
          cnt_d   = '0;
          state_d = (mode_q == 2'd1) ? WR_GO : WR_KEY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR_KEY: begin
        if (cnt_q == CW'(pKEY_BYTES - 1)) begin
          cnt_d = '0;
          if (mode_q == 2'd3) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = WR_GO;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR_GO: begin
        tcnt_d  = tcnt_inc;
        sub_d   = '0;
        state_d = POLL_RD;
      end
      POLL_RD: begin
        tcnt_d = tcnt_inc;
        sub_d  = sub_q + SW'(1);
        if (sub_q == SW'(pRD_LAT)) begin
          sub_d = '0;
          lat_d = (tcnt_q > TW'(16'hFFFF)) ? 16'hFFFF : tcnt_q[15:0];
          if (reg_rdata_i[0]) begin
            state_d = POLL_GAP;
          end else begin
            cnt_d   = '0;
            state_d = RD_OUT;
          end
        end
      end
      POLL_GAP: begin
        tcnt_d = tcnt_inc;
        sub_d  = sub_q + SW'(1);
        if (sub_q == SW'(pPOLL_GAP - 1)) begin
          sub_d   = '0;
          state_d = POLL_RD;
        end
      end
      RD_OUT: begin
        sub_d = sub_q + SW'(1);
        if (sub_q == SW'(pRD_LAT)) begin
          sub_d = '0;
          for (int k = 0; k < int'(pOUT_BYTES); k++) begin
            if (cnt_q == CW'(k)) result_d[8*k +: 8] = reg_rdata_i;
          end
          if (cnt_q == CW'(pOUT_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = CMP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CMP: begin
        pass_d  = (mode_q == 2'd2) || (result_q == expct_q);
        fail_d  = !pass_d;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (fail_q && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase

    // Timeout beats a poll completing on the same edge; any read in flight is dropped.
    if (wait_st && (tcnt_inc >= TW'(pTIMEOUT))) begin
      state_d = DONE;
      to_d    = 1'b1;
      fail_d  = 1'b1;
      pass_d  = 1'b0;
      lat_d   = (tcnt_inc > TW'(16'hFFFF)) ? 16'hFFFF : tcnt_inc[15:0];
    end

    if (clr_i) err_d = '0;
  end

  // Bus strobes are decoded from the next state so they line up with the state they belong to.
  always_comb begin
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      WR_TEXT: begin
        wr_d   = 1'b1;
        addr_d = {2'b00, pREG_TEXTIN, cnt_d};
        for (int k = 0; k < int'(pTEXT_BYTES); k++) begin
          if (cnt_d == CW'(k)) wdata_d = text_d[8*k +: 8];
        end
      end
      WR_KEY: begin
        wr_d   = 1'b1;
        addr_d = {2'b00, pREG_KEY, cnt_d};
        for (int k = 0; k < int'(pKEY_BYTES); k++) begin
          if (cnt_d == CW'(k)) wdata_d = key_d[8*k +: 8];
        end
      end
      WR_GO: begin
        wr_d    = 1'b1;
        addr_d  = {2'b00, pREG_GO, CW'(0)};
        wdata_d = 8'h01;
      end
      POLL_RD: begin
        rd_d   = (sub_d == '0);
        addr_d = {2'b00, pREG_GO, CW'(0)};
      end
      RD_OUT: begin
        rd_d   = (sub_d == '0);
        addr_d = {2'b00, pREG_CIPHEROUT, cnt_d};
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_write_o = wr_q;
  assign reg_read_o  = rd_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = to_q;
  assign result_o    = result_q;
  assign err_count_o = err_q;
  assign latency_o   = lat_q;

endmodule

// File: tb/tb_crypt_selftest_seq.sv
// Directed bench for crypt_selftest_seq with a behavioural register-bus slave.
module tb_crypt_selftest_seq;

  localparam logic [127:0] RES  = 128'h8a278bf8fa2812bc39e52c76205af377;
  localparam logic [127:0] TEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  logic         usb_clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   mode_i = 2'd0;
  logic         clr_i = 1'b0;
  logic [127:0] text_i = '0, key_i = '0, expected_i = '0;
  logic [14:0]  reg_addr_o;
  logic [7:0]   reg_wdata_o;
  logic         reg_write_o, reg_read_o;
  logic [7:0]   reg_rdata_i = 8'hEE;
  logic         busy_o, done_o, pass_o, fail_o, timeout_o;
  logic [127:0] result_o;
  logic [15:0]  err_count_o, latency_o;

  crypt_selftest_seq #(.pTIMEOUT(200)) dut (
    .usb_clk(usb_clk), .resetn(resetn), .start_i(start_i), .mode_i(mode_i), .clr_i(clr_i),
    .text_i(text_i), .key_i(key_i), .expected_i(expected_i),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_write_o(reg_write_o),
    .reg_read_o(reg_read_o), .reg_rdata_i(reg_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .result_o(result_o), .err_count_o(err_count_o), .latency_o(latency_o)
  );

  always #5 usb_clk = ~usb_clk;

  int checks = 0;
  int errors = 0;

  // Bus monitor, sampled just after each rising edge.
  int cyc = 0, wr_tot = 0, key_tot = 0, go_tot = 0, gord_tot = 0, out_tot = 0;
  int done_tot = 0, go_cyc = 0, done_cyc = 0, cur_run = 0, last_run = 0, wdata_viol = 0;
  always @(posedge usb_clk) begin
    #1;
    cyc++;
    if (reg_write_o) begin
      wr_tot++;
      cur_run++;
      if (reg_addr_o[12:7] == 6'd5) key_tot++;
      if (reg_addr_o[12:7] == 6'd6) begin go_tot++; go_cyc = cyc; end
    end else begin
      if (cur_run > 0) last_run = cur_run;
      cur_run = 0;
      if (reg_wdata_o != 8'h00) wdata_viol++;
    end
    if (reg_read_o) begin
      if (reg_addr_o[12:7] == 6'd6) gord_tot++;
      if (reg_addr_o[12:7] == 6'd7) out_tot++;
    end
    if (done_o) begin done_tot++; done_cyc = cyc; end
  end

  // Slave: data valid exactly two cycles after the read pulse, garbage otherwise.
  int slv_busy_n = 0;
  int go_base = 0;
  logic        s0_v = 1'b0, s1_v = 1'b0;
  logic [14:0] s0_a = '0, s1_a = '0;
  logic [127:0] res_vec = RES;

  function automatic logic [7:0] resp(input logic [14:0] a);
    int n;
    logic [7:0] r;
    r = 8'hEE;
    if (a[12:7] == 6'd6) begin
      n = gord_tot - go_base;
      r = {7'b0, ((slv_busy_n < 0) || (n <= slv_busy_n))};
    end else if (a[12:7] == 6'd7) begin
      r = res_vec[8*a[6:0] +: 8];
    end
    return r;
  endfunction

  always @(negedge usb_clk) begin
    reg_rdata_i <= s1_v ? resp(s1_a) : 8'hEE;
    s1_v <= s0_v;
    s1_a <= s0_a;
    s0_v <= reg_read_o;
    s0_a <= reg_addr_o;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]   mode;
    int           busy_n;
    logic [127:0] expv;
    bit           clr;
    int           writes, keys, gos, polls, outs;
    bit           pass, fail, tmo;
    int           err, lat;
  } row_t;

  row_t rows[8];
  int b_wr, b_key, b_go, b_out, b_done;

  task automatic start_run(input row_t r, input string nm);
    b_wr = wr_tot; b_key = key_tot; b_go = go_tot; b_out = out_tot; b_done = done_tot;
    go_base = gord_tot;
    slv_busy_n = r.busy_n;
    mode_i = r.mode; text_i = TEXT; key_i = KEY; expected_i = r.expv;
    start_i = 1'b1;
    @(negedge usb_clk);
    start_i = 1'b0;
    chk({nm, "_first_wr"}, 128'({reg_write_o, reg_addr_o, reg_wdata_o}),
        (r.mode == 2'd3) ? 128'({1'b1, 2'b00, 6'd5, 7'd0, KEY[7:0]})
                         : 128'({1'b1, 2'b00, 6'd4, 7'd0, TEXT[7:0]}));
  endtask

  task automatic wait_done(input string nm, input bit clr_at_done);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_o) begin seen = 1'b1; break; end
      @(negedge usb_clk);
    end
    chk({nm, "_done_seen"}, 128'(seen), 128'(1));
    if (clr_at_done) clr_i = 1'b1;
  endtask

  task automatic check_row(input row_t r, input string nm);
    chk({nm, "_pass"}, 128'(pass_o), 128'(r.pass));
    chk({nm, "_fail"}, 128'(fail_o), 128'(r.fail));
    chk({nm, "_timeout"}, 128'(timeout_o), 128'(r.tmo));
    chk({nm, "_result"}, result_o, RES);
    chk({nm, "_latency"}, 128'(latency_o), 128'(r.lat));
    chk({nm, "_writes"}, 128'(wr_tot - b_wr), 128'(r.writes));
    chk({nm, "_key_wr"}, 128'(key_tot - b_key), 128'(r.keys));
    chk({nm, "_go_wr"}, 128'(go_tot - b_go), 128'(r.gos));
    if (r.polls >= 0) chk({nm, "_polls"}, 128'(gord_tot - go_base), 128'(r.polls));
    chk({nm, "_out_rd"}, 128'(out_tot - b_out), 128'(r.outs));
    if (r.tmo) chk({nm, "_to_bound"}, 128'((done_cyc - go_cyc) <= 203), 128'(1));
    @(negedge usb_clk);
    clr_i = 1'b0;
    chk({nm, "_done_end"}, 128'({done_o, busy_o}), 128'(0));
    chk({nm, "_done_cnt"}, 128'(done_tot - b_done), 128'(1));
    chk({nm, "_err"}, 128'(err_count_o), 128'(r.err));
    chk({nm, "_burst"}, 128'(last_run), 128'(r.writes));
  endtask

  initial begin
    row_t r;
    rows[0] = '{2'd0,  3, RES,               1'b0, 33, 16, 1,  4, 16, 1'b1, 1'b0, 1'b0, 0,  24};
    rows[1] = '{2'd0,  3, RES ^ 128'h1,      1'b0, 33, 16, 1,  4, 16, 1'b0, 1'b1, 1'b0, 1,  24};
    rows[2] = '{2'd0,  3, RES ^ 128'h1,      1'b0, 33, 16, 1,  4, 16, 1'b0, 1'b1, 1'b0, 2,  24};
    rows[3] = '{2'd1,  0, RES,               1'b0, 17,  0, 1,  1, 16, 1'b1, 1'b0, 1'b0, 2,   3};
    rows[4] = '{2'd3,  0, RES ^ 128'h5,      1'b0, 16, 16, 0,  0,  0, 1'b1, 1'b0, 1'b0, 2,   3};
    rows[5] = '{2'd2,  1, RES ^ 128'hFF,     1'b0, 33, 16, 1,  2, 16, 1'b1, 1'b0, 1'b0, 2,  10};
    rows[6] = '{2'd0,  3, RES ^ 128'h1,      1'b1, 33, 16, 1,  4, 16, 1'b0, 1'b1, 1'b0, 0,  24};
    rows[7] = '{2'd0, -1, RES,               1'b0, 33, 16, 1, -1,  0, 1'b0, 1'b1, 1'b1, 1, 200};

    // Reset with a coincident start: everything zero and the start is dropped.
    start_i = 1'b1;
    repeat (3) @(negedge usb_clk);
    chk("reset_outs", 128'({busy_o, done_o, pass_o, fail_o, timeout_o, reg_write_o, reg_read_o,
                            reg_addr_o, reg_wdata_o, err_count_o, latency_o}), 128'(0));
    chk("reset_result", result_o, 128'(0));
    resetn = 1'b1;
    start_i = 1'b0;
    @(negedge usb_clk);
    chk("start_dropped", 128'(busy_o), 128'(0));

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("row%0d", i);
      start_run(rows[i], nm);
      wait_done(nm, rows[i].clr);
      check_row(rows[i], nm);
      repeat (2) @(negedge usb_clk);
    end

    // Start pulsed during RD_OUT must be ignored.
    r = rows[0];
    r.err = 1;
    start_run(r, "rdout_start");
    for (int i = 0; i < 500 && (out_tot - b_out) < 3; i++) @(negedge usb_clk);
    chk("rdout_reached", 128'((out_tot - b_out) >= 3), 128'(1));
    mode_i = 2'd3;
    start_i = 1'b1;
    @(negedge usb_clk);
    start_i = 1'b0;
    wait_done("rdout_start", 1'b0);
    check_row(r, "rdout_start");
    b_wr = wr_tot;
    repeat (10) @(negedge usb_clk);
    chk("rdout_no_extra", 128'({busy_o, 32'(wr_tot - b_wr)}), 128'(0));

    // Reset while waiting in POLL_GAP, then a clean run.
    start_run(rows[0], "rst_gap");
    for (int i = 0; i < 500 && (gord_tot - go_base) < 1; i++) @(negedge usb_clk);
    chk("rst_gap_poll", 128'((gord_tot - go_base) >= 1), 128'(1));
    repeat (3) @(negedge usb_clk);
    resetn = 1'b0;
    @(negedge usb_clk);
    chk("rst_gap_outs", 128'({busy_o, done_o, pass_o, fail_o, timeout_o, reg_write_o, reg_read_o,
                              reg_addr_o, reg_wdata_o, err_count_o, latency_o}), 128'(0));
    chk("rst_gap_result", result_o, 128'(0));
    resetn = 1'b1;
    @(negedge usb_clk);
    start_run(rows[0], "after_rst");
    wait_done("after_rst", 1'b0);
    check_row(rows[0], "after_rst");

    chk("wdata_idle_zero", 128'(wdata_viol), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
